// File: rtl/spi_write_controller.sv
// rtl/spi_write_controller.sv - SPI mode-0 initiator serialising 16-bit register command frames
//
// Purpose: accepts one {rw, addr[6:0], data[7:0]} command per cmd_valid/cmd_ready
// handshake and shifts it out MSB first on SCLK/nCS/COPI. Every bus output is a
// flop, so the pins are glitch-free.
// Optional feature macro: SPI_CTRL_READBACK_EN (adds CIPO, rd_data, rd_valid).
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_rw, cmd_addr, cmd_data  frame fields (bit 15, bits 14:8, bits 7:0)
//   busy                        frame or inter-frame gap in progress
//   done                        one-cycle pulse when nCS returns high
//   SCLK, nCS, COPI             serial bus (SCLK idle low, nCS idle high)
//   CIPO, rd_data, rd_valid     read data capture (SPI_CTRL_READBACK_EN only)
module spi_write_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
`ifdef SPI_CTRL_READBACK_EN
  input  logic       CIPO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
`endif
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [3:0]       bit_cnt;
  // Frame bit 15 goes straight to COPI at the handshake, so only bits 14:0 are held.
  logic [14:0]      shift;
`ifdef SPI_CTRL_READBACK_EN
  logic             frame_rw;
  logic [7:0]       rd_shift;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      SCLK      <= 1'b0;
      nCS       <= 1'b1;
      COPI      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SPI_CTRL_READBACK_EN
      frame_rw  <= 1'b0;
      rd_shift  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_CTRL_READBACK_EN
      rd_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            shift     <= {cmd_addr, cmd_data};
            COPI      <= cmd_rw;
            nCS       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            div_cnt   <= DIV_LAST;
            bit_cnt   <= '0;
`ifdef SPI_CTRL_READBACK_EN
            frame_rw  <= cmd_rw;
`endif
            state     <= SETUP;
          end else begin
            // Also covers the first cycle after reset release.
            cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (div_cnt == '0) begin
            SCLK    <= 1'b1;
            div_cnt <= DIV_LAST;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end

        HIGH: begin
          if (div_cnt == '0) begin
            SCLK    <= 1'b0;
            div_cnt <= DIV_LAST;
            bit_cnt <= bit_cnt + 4'd1;
            // After the 16th high phase COPI parks low for the hold phase.
            if (bit_cnt == 4'd15) begin
              COPI <= 1'b0;
            end else begin
              COPI  <= shift[14];
              shift <= {shift[13:0], 1'b0};
            end
`ifdef SPI_CTRL_READBACK_EN
            // High phases 9..16 carry the peripheral's data bits 7..0.
            if (!frame_rw && bit_cnt[3])
              rd_shift <= {rd_shift[6:0], CIPO};
`endif
            state <= LOW;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end

        LOW: begin
          if (div_cnt == '0) begin
            // bit_cnt has wrapped to 0 only once all 16 high phases are done.
            if (bit_cnt == 4'd0) begin
              nCS     <= 1'b1;
              done    <= 1'b1;
              gap_cnt <= GAP_LAST;
`ifdef SPI_CTRL_READBACK_EN
              if (!frame_rw) begin
                rd_data  <= rd_shift;
                rd_valid <= 1'b1;
              end
`endif
              state <= GAP;
            end else begin
              SCLK    <= 1'b1;
              div_cnt <= DIV_LAST;
              state   <= HIGH;
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
